rv_fetch_unit: RTL and testbench

- Decoupled instruction-fetch front end for the pipelined RV32I core.
- Replaces the fixed PC register and combinational ROM read with:
  - a PC generator;
  - a req/gnt/rvalid instruction-memory handshake with multiple outstanding requests;
  - a parametrised instruction queue feeding decode through valid/ready.
- Branch/jump redirects from EX flush the queue and discard in-flight responses.

---
 rtl/rv_fetch_pkg.sv | 10 +
 rtl/rv_fetch_queue.sv | 44 ++++
 rtl/rv_fetch_unit.sv | 81 ++++++++
 tb/tb_rv_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared constants and queue entry layout for the instruction fetch front end
package rv_fetch_pkg;
  localparam logic [31:0] RV_NOP              = 32'h0000_0013;
  localparam logic [31:0] RV_DEFAULT_RESET_PC = 32'h0040_0000;
  localparam int          PC_INCR             = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: synchronous FIFO of fetched {pc, instr} entries
// Ports: clk, reset (async, active-low); i_push/i_data write; i_pop advances head;
//        i_flush empties the queue and dominates push/pop; o_data is the head; o_count occupancy.
module rv_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;
  logic             w_pop, w_push;
  // a push at full is accepted only when the head leaves in the same cycle
  assign w_pop   = i_pop && r_count != '0;
  assign w_push  = i_push && (r_count != (AW+1)'(DEPTH) || w_pop);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_mem <= '{default: '0};
    else if (w_push && !i_flush) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: decoupled RV32I fetch front end with req/gnt/rvalid memory port and instruction queue
// Ports: clk, reset (async, active-low);
//        imem_req/imem_addr/imem_gnt issue side, imem_rvalid/imem_rdata in-order responses;
//        redirect_valid/redirect_target from EX; id_valid/id_instr/id_pc/id_ready to decode;
//        iq_count reports queue occupancy.
module rv_fetch_unit import rv_fetch_pkg::*; #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = RV_DEFAULT_RESET_PC,
  parameter int                    IQ_DEPTH        = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [ADDR_WIDTH-1:0]     imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [DATA_WIDTH-1:0]     imem_rdata,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_target,
  output logic                      id_valid,
  output logic [DATA_WIDTH-1:0]     id_instr,
  output logic [ADDR_WIDTH-1:0]     id_pc,
  input  logic                      id_ready,
  output logic [$clog2(IQ_DEPTH):0] iq_count
);
  localparam int CW = $clog2(IQ_DEPTH) + 1;
  logic [ADDR_WIDTH-1:0]            r_fetch_pc, r_resp_pc;
  logic [CW-1:0]                    r_outstanding, r_discard;
  logic [ADDR_WIDTH-1:0]            w_target, w_fetch_pc_nx, w_resp_pc_nx;
  logic [CW-1:0]                    w_outstanding_nx, w_discard_nx;
  logic [CW:0]                      w_level;
  logic                             w_fire, w_push;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;
  assign w_target = redirect_target & ~ADDR_WIDTH'(3);
  // granted-but-unanswered requests already own a queue slot, so issue is credit-limited
  assign w_level  = {1'b0, r_outstanding} + {1'b0, iq_count};
  // reset gates the request so it reads 0 while reset is held, not only after the first edge
  assign imem_req = reset && !redirect_valid && r_outstanding < CW'(MAX_OUTSTANDING) &&
                    w_level < (CW+1)'(IQ_DEPTH);
  assign imem_addr = r_fetch_pc;
  assign w_fire    = imem_req && imem_gnt;
  // stale responses from before a redirect are counted off by r_discard
  assign w_push    = imem_rvalid && !redirect_valid && r_discard == '0;
  always_comb begin
    w_fetch_pc_nx    = redirect_valid ? w_target : w_fire ? r_fetch_pc + ADDR_WIDTH'(PC_INCR) : r_fetch_pc;
    w_resp_pc_nx     = redirect_valid ? w_target : w_push ? r_resp_pc + ADDR_WIDTH'(PC_INCR) : r_resp_pc;
    w_outstanding_nx = r_outstanding + CW'(w_fire) - CW'(imem_rvalid);
    w_discard_nx     = redirect_valid ? r_outstanding - CW'(imem_rvalid) :
                       (imem_rvalid && r_discard != '0) ? r_discard - CW'(1) : r_discard;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_fetch_pc    <= w_fetch_pc_nx;
      r_resp_pc     <= w_resp_pc_nx;
      r_outstanding <= w_outstanding_nx;
      r_discard     <= w_discard_nx;
    end
  rv_fetch_queue #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (IQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, imem_rdata}),
    .i_pop   (id_valid && id_ready),
    .i_flush (redirect_valid),
    .o_data  (w_head),
    .o_count (iq_count)
  );
  assign id_valid = iq_count != '0;
  assign id_pc    = id_valid ? w_head[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign id_instr = id_valid ? w_head[DATA_WIDTH-1:0] : DATA_WIDTH'(RV_NOP);
endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed stimulus with an in-order memory model and a scoreboard on the decode port
module tb_rv_fetch_unit;
  import rv_fetch_pkg::*;
  logic        clk = 0, reset = 1;
  logic        imem_req, imem_gnt, imem_rvalid = 0, redirect_valid = 0, id_valid, id_ready = 1;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_target = 0, id_instr, id_pc;
  logic [2:0]  iq_count;
  logic        gnt_en = 1, rsp_en = 1;
  int          tests = 0, fails = 0, epoch = 0;
  typedef struct {logic [31:0] addr; int ep;} req_t;
  req_t         pend[$];
  fetch_entry_t exp_q[$];

  rv_fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .iq_count(iq_count)
  );

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hdead_0013;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!id_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!id_valid) begin
      tests++;
      fails++;
      $display("FAIL %s: id_valid still 0 after 20 cycles, required 1", name);
    end
  endtask

  // memory model: single-cycle responses while rsp_en, answered in grant order
  always @(posedge clk) begin
    #2;
    imem_rvalid = rsp_en && pend.size() > 0;
    imem_rdata  = pend.size() > 0 ? mem_word(pend[0].addr) : 32'h0;
  end

  // requests granted before the latest redirect (older epoch) must never reach decode
  always @(negedge clk) begin
    if (!reset) begin
      pend.delete();
      epoch++;
    end else begin
      if (imem_rvalid && pend.size() > 0) begin
        if (!redirect_valid && pend[0].ep == epoch)
          exp_q.push_back('{pc: pend[0].addr, instr: mem_word(pend[0].addr)});
        pend.delete(0);
      end
      if (imem_req && imem_gnt) pend.push_back('{addr: imem_addr, ep: epoch});
      if (redirect_valid) epoch++;
    end
  end

  // monitor: every accepted decode entry must match the scoreboard head
  always @(negedge clk) begin
    if (!reset) exp_q.delete();
    else begin
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got pc %h instr %h, required no entry", id_pc, id_instr);
        end else begin
          chk("sb_pc", id_pc, exp_q[0].pc);
          chk("sb_instr", id_instr, exp_q[0].instr);
          exp_q.delete(0);
        end
      end
      if (redirect_valid) exp_q.delete();
      tests++;
      if (dut.r_discard > dut.r_outstanding || dut.r_outstanding > 2) begin
        fails++;
        $display("FAIL invariant: discard %0d outstanding %0d, required discard<=outstanding<=2",
                 dut.r_discard, dut.r_outstanding);
      end
    end
  end

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, 32'h0040_0000);
    chk({tag, "_valid"}, id_valid, 0);
    chk({tag, "_instr"}, id_instr, 32'h0000_0013);
    chk({tag, "_pc"}, id_pc, 0);
    chk({tag, "_count"}, iq_count, 0);
  endtask

  initial begin
    #1 reset = 0;
    #1 chk_reset_outputs("rst");
    repeat (3) @(posedge clk);
    #1 reset = 1;
    // cold start with single-cycle memory
    @(negedge clk);
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 32'h0040_0000);
    chk("c0_valid", id_valid, 0);
    @(negedge clk);
    chk("c1_addr", imem_addr, 32'h0040_0004);
    chk("c1_valid", id_valid, 0);
    @(negedge clk);
    chk("c2_valid", id_valid, 1);
    chk("c2_pc", id_pc, 32'h0040_0000);
    chk("c2_instr", id_instr, 32'hdeed_0013);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_valid", id_valid, 1);
      chk("stream_addr", imem_addr, 32'h0040_000C + 4 * i);
      chk("stream_pc", id_pc, 32'h0040_0004 + 4 * i);
    end
    // decode stall: issue must stop at the credit limit
    @(posedge clk);
    #1 id_ready = 0;
    repeat (4) @(negedge clk);
    chk("stall_req", imem_req, 0);
    chk("stall_count", iq_count, 4);
    chk("stall_head", id_pc, 32'h0040_001C);
    @(negedge clk);
    chk("stall_hold_req", imem_req, 0);
    chk("stall_hold_count", iq_count, 4);
    @(posedge clk);
    #1 id_ready = 1;
    @(negedge clk);
    chk("resume_req0", imem_req, 0);
    @(negedge clk);
    chk("resume_req1", imem_req, 1);
    chk("resume_addr", imem_addr, 32'h0040_002C);
    repeat (12) @(negedge clk);
    // redirect with two requests still in flight
    @(posedge clk);
    #1 rsp_en = 0;
    @(negedge clk);
    @(negedge clk);
    chk("os_full_req", imem_req, 0);
    @(posedge clk);
    #1 redirect_valid = 1;
    redirect_target = 32'h0040_0103;
    @(negedge clk);
    chk("redir_req", imem_req, 0);
    @(posedge clk);
    #1 redirect_valid = 0;
    rsp_en = 1;
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h0040_0100);
    chk("redir_empty", id_valid, 0);
    wait_valid("redir_wait");
    chk("redir_first_pc", id_pc, 32'h0040_0100);
    chk("redir_first_instr", id_instr, 32'hdeed_0113);
    repeat (6) @(negedge clk);
    // redirect coinciding with a response and a pop, one request outstanding
    @(posedge clk);
    #1 redirect_valid = 1;
    redirect_target = 32'h0040_0200;
    @(negedge clk);
    chk("same_pop_valid", id_valid, 1);
    chk("same_req", imem_req, 0);
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("same_discard", dut.r_discard, 0);
    chk("same_empty", id_valid, 0);
    chk("same_count", iq_count, 0);
    chk("same_req1", imem_req, 1);
    chk("same_addr", imem_addr, 32'h0040_0200);
    wait_valid("same_wait");
    chk("same_first_pc", id_pc, 32'h0040_0200);
    repeat (4) @(negedge clk);
    // back-to-back redirects: the later target wins
    @(posedge clk);
    #1 redirect_valid = 1;
    redirect_target = 32'h0040_0300;
    @(posedge clk);
    #1 redirect_target = 32'h0040_0404;
    @(posedge clk);
    #1 redirect_valid = 0;
    @(negedge clk);
    chk("b2b_addr", imem_addr, 32'h0040_0404);
    wait_valid("b2b_wait");
    chk("b2b_first_pc", id_pc, 32'h0040_0404);
    repeat (4) @(negedge clk);
    // reset in the middle of a burst with two outstanding
    @(posedge clk);
    #1 rsp_en = 0;
    @(posedge clk);
    #1 reset = 0;
    #1 chk_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1;
    rsp_en = 1;
    // restart, then withhold the grant for three cycles
    @(negedge clk);
    chk("rs_req", imem_req, 1);
    chk("rs_addr", imem_addr, 32'h0040_0000);
    @(posedge clk);
    #1 gnt_en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req", imem_req, 1);
      chk("hold_addr", imem_addr, 32'h0040_0004);
      if (i == 1) chk("rs_first_pc", id_pc, 32'h0040_0000);
    end
    @(posedge clk);
    #1 gnt_en = 1;
    @(negedge clk);
    chk("hold_release_addr", imem_addr, 32'h0040_0004);
    @(negedge clk);
    chk("hold_next_addr", imem_addr, 32'h0040_0008);
    repeat (6) @(negedge clk);
    // drain everything and confirm nothing is left unaccounted for
    @(posedge clk);
    #1 gnt_en = 0;
    repeat (10) @(negedge clk);
    chk("drain_sb", exp_q.size(), 0);
    chk("drain_count", iq_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
